regfile_ram_sequencer: RTL and testbench
========================================

REGFILE_RAM_SEQUENCER -- requirements
Module: regfile_ram_sequencer

Interface
REQ-001 SHALL have parameter: DW, 32, data width.
REQ-002 SHALL have parameter: SPILL_AW, 4, spill-RAM word address width (register address bits [3:0]).
REQ-003 SHALL have parameter: TIMEOUT, 255, max cycles waiting for ram_ack.
REQ-004 SHALL have port: CLK  input  1  rising-edge clock.
REQ-005 SHALL have port: RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: prog_mode  input  1  programming mode; synchronous abort to IDLE.
REQ-007 SHALL have port: req_valid  input  1  operand/writeback request from decode.
REQ-008 SHALL have port: req_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports: rs1, rs2, rd  input  5 each  register addresses; bit 4 set = spill RAM.
REQ-010 SHALL have ports: use_rs1, use_rs2  input  1 each  operand actually read (not PC/immediate).
REQ-011 SHALL have ports: wr_en  input  1; wr_data  input  DW  writeback to rd.
REQ-012 SHALL have ports: op1, op2  output  DW  spilled operand values; op_valid  output  1  one-cycle done pulse.
REQ-013 SHALL have port: stall  output  1  pipeline hold while RAM transactions are pending.
REQ-014 SHALL have ports: ram_req, ram_we  output  1; ram_addr  output  SPILL_AW; ram_wdata  output  DW; ram_ack  input  1; ram_rdata  input  DW.
REQ-015 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-016 Request SHALL be captured (rs1, rs2, rd, use_*, wr_en, wr_data) on a cycle with req_valid && req_ready; req_ready = (state==IDLE) && !prog_mode.
REQ-017 Classification: sp1 = use_rs1 && rs1[4]; sp2 = use_rs2 && rs2[4]; spw = wr_en && rd!=0 && rd[4].
REQ-018 States IDLE, RD1, RD2, WR, DONE; from IDLE on accept go to first of RD1/RD2/WR that is needed, in that order, else DONE.
REQ-019 RD1 -> next needed of RD2/WR, else DONE, on ram_ack; same for RD2 -> WR/DONE; WR -> DONE on ram_ack; DONE -> IDLE unconditionally.
REQ-020 If sp1 && sp2 && rs1==rs2, RD2 SHALL be skipped and op2 copied from op1 data.
REQ-021 Reads SHALL precede the write, so rd==rs returns the pre-write value.
REQ-022 In RD/WR states ram_req SHALL be 1 and ram_we/ram_addr/ram_wdata stable until the ram_ack cycle; ram_req drops the cycle after ack; ram_ack outside RD/WR ignored.
REQ-023 ram_rdata SHALL be captured into op1/op2 on the ram_ack cycle; non-spilled operands output 0.
REQ-024 op1/op2 SHALL hold until the next accept; op_valid = 1 only in DONE.
REQ-025 stall SHALL be 1 in RD1/RD2/WR, 0 in IDLE/DONE; no-spill request yields op_valid one cycle after accept with no ram_req.
REQ-026 8-bit wait counter SHALL clear on state entry; reaching TIMEOUT in RD/WR sets err, forces unread spilled operands to 32'hFFFFFFFF, goes to DONE.
REQ-027 prog_mode=1 SHALL force IDLE next edge, drop ram_req, clear err, op1/op2 = 0.

Reset
REQ-028 RESET SHALL immediately force state IDLE, ram_req/ram_we/op_valid/err = 0, ram_addr/ram_wdata/op1/op2 = 0, counter 0, including mid-transaction.
REQ-029 After RESET deassertion req_ready SHALL be 1 on the first edge if prog_mode=0.

Structure
REQ-030 Package regfile_seq_pkg SHALL hold the state enum, SPILL_BIT=4, default TIMEOUT, and fill constant 32'hFFFFFFFF.
REQ-031 One sub-module, regfile_seq_timer (loadable wait counter with expiry flag), SHALL be instantiated.

Verification
REQ-032 rs1=5'h03, rs2=5'h04, rd=5'h05, use both, wr_en=1 -> op_valid one cycle after accept, ram_req never 1.
REQ-033 rs1=5'h12, rs2=5'h04, rd=5'h1A, wr_data=0xCAFE0001, ack after 2 cycles each -> read addr 2 then write addr 0xA data 0xCAFE0001, op1=ram_rdata.
REQ-034 rs1=rs2=5'h17, ram_rdata=0x12345678 -> single read at addr 7, op1=op2=0x12345678.
REQ-035 rs1=5'h11, ram_ack never asserted, TIMEOUT=4 -> err=1, op1=0xFFFFFFFF, op_valid pulse, then IDLE.
REQ-036 RESET pulsed in RD2 -> ram_req=0 and state IDLE immediately; prog_mode=1 in WR -> IDLE next edge, err=0.

Source files
------------

// File: rtl/regfile_ram_sequencer_pkg.sv
// Shared types and constants for the register-file spill-RAM sequencer.
// Defines the FSM state encoding and the helper that picks the next RAM step.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int          SPILL_BIT       = 4;
  localparam int          DEFAULT_TIMEOUT = 255;
  localparam int          TMR_W           = 8;
  localparam logic [31:0] FILL_WORD       = 32'hFFFF_FFFF;

  // Reads always come before the write, so rd==rs yields the old value.
  function automatic state_t first_needed(input logic need_rd1,
                                          input logic need_rd2,
                                          input logic need_wr);
    if (need_rd1)      return RD1;
    else if (need_rd2) return RD2;
    else if (need_wr)  return WR;
    else               return DONE;
  endfunction

  function automatic logic is_ram_state(input state_t s);
    return (s == RD1) || (s == RD2) || (s == WR);
  endfunction

endpackage

// File: rtl/regfile_ram_sequencer_if.sv
// Spill-RAM bus between the sequencer (master) and the RAM (slave).
// One request outstanding at a time; ram_ack completes it.
interface regfile_ram_sequencer_if #(
  parameter int DW       = 32,
  parameter int SPILL_AW = 4
) ();

  logic                ram_req;
  logic                ram_we;
  logic [SPILL_AW-1:0] ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic                ram_ack;
  logic [DW-1:0]       ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );

endinterface

// File: rtl/regfile_seq_timer.sv
// Loadable wait down-counter; expired marks the cycle where TIMEOUT cycles
// have elapsed since the load pulse (load happens on the first state cycle).
module regfile_seq_timer
  import regfile_seq_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && !load && (cnt == '0);

endmodule

// File: rtl/regfile_ram_sequencer.sv
// Fetches spilled operands (regs 16..31) from a side RAM and writes spilled
// results back, holding the pipeline until every RAM transaction completes.
//
//   state | meaning
//   IDLE  | ready for a decode request
//   RD1   | reading spilled rs1
//   RD2   | reading spilled rs2 (skipped when rs1==rs2)
//   WR    | writing wr_data to spilled rd
//   DONE  | op1/op2 valid for one cycle
module regfile_ram_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DW       = 32,
  parameter int SPILL_AW = 4,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      prog_mode,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  input  logic [4:0]                rd,
  input  logic                      use_rs1,
  input  logic                      use_rs2,
  input  logic                      wr_en,
  input  logic [DW-1:0]             wr_data,
  output logic [DW-1:0]             op1,
  output logic [DW-1:0]             op2,
  output logic                      op_valid,
  output logic                      stall,
  output logic                      err,
  regfile_ram_sequencer_if.master   ram
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t              state;
  logic                ram_req_q;
  logic                ram_we_q;
  logic [SPILL_AW-1:0] ram_addr_q;
  logic [DW-1:0]       ram_wdata_q;
  logic [SPILL_AW-1:0] rs2_q;
  logic [SPILL_AW-1:0] rd_q;
  logic                sp2_q;
  logic                need2_q;
  logic                spw_q;
  logic                same_q;
  logic                tmr_load;
  logic                tmr_expired;

  logic   sp1;
  logic   sp2;
  logic   spw;
  logic   same;
  logic   need2;
  state_t acc_next;
  state_t rd1_next;

  assign sp1      = use_rs1 && rs1[SPILL_BIT];
  assign sp2      = use_rs2 && rs2[SPILL_BIT];
  assign spw      = wr_en && (rd != 5'd0) && rd[SPILL_BIT];
  assign same     = sp1 && sp2 && (rs1 == rs2);
  assign need2    = sp2 && !same;
  assign acc_next = first_needed(sp1, need2, spw);
  assign rd1_next = first_needed(1'b0, need2_q, spw_q);

  assign req_ready     = (state == IDLE) && !prog_mode;
  assign ram.ram_req   = ram_req_q;
  assign ram.ram_we    = ram_we_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_wdata = ram_wdata_q;

  regfile_seq_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (tmr_load),
    .load_val (TMR_LOAD),
    .en       (stall),
    .expired  (tmr_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      op1         <= '0;
      op2         <= '0;
      op_valid    <= 1'b0;
      stall       <= 1'b0;
      err         <= 1'b0;
      rs2_q       <= '0;
      rd_q        <= '0;
      sp2_q       <= 1'b0;
      need2_q     <= 1'b0;
      spw_q       <= 1'b0;
      same_q      <= 1'b0;
      tmr_load    <= 1'b0;
    end else if (prog_mode) begin
      state     <= IDLE;
      ram_req_q <= 1'b0;
      ram_we_q  <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      op_valid  <= 1'b0;
      stall     <= 1'b0;
      err       <= 1'b0;
      tmr_load  <= 1'b0;
    end else begin
      tmr_load <= 1'b0;
      op_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rs2_q       <= rs2[SPILL_AW-1:0];
            rd_q        <= rd[SPILL_AW-1:0];
            sp2_q       <= sp2;
            need2_q     <= need2;
            spw_q       <= spw;
            same_q      <= same;
            op1         <= '0;
            op2         <= '0;
            state       <= acc_next;
            ram_req_q   <= is_ram_state(acc_next);
            ram_we_q    <= (acc_next == WR);
            ram_addr_q  <= sp1   ? rs1[SPILL_AW-1:0] :
                           need2 ? rs2[SPILL_AW-1:0] : rd[SPILL_AW-1:0];
            ram_wdata_q <= wr_data;
            stall       <= is_ram_state(acc_next);
            tmr_load    <= is_ram_state(acc_next);
            op_valid    <= (acc_next == DONE);
          end
        end
        RD1: begin
          if (ram.ram_ack) begin
            op1 <= ram.ram_rdata;
            if (same_q) op2 <= ram.ram_rdata;
            state      <= rd1_next;
            ram_req_q  <= is_ram_state(rd1_next);
            ram_we_q   <= (rd1_next == WR);
            ram_addr_q <= need2_q ? rs2_q : rd_q;
            stall      <= is_ram_state(rd1_next);
            tmr_load   <= is_ram_state(rd1_next);
            op_valid   <= (rd1_next == DONE);
          end else if (tmr_expired) begin
            op1 <= DW'(FILL_WORD);
            if (sp2_q) op2 <= DW'(FILL_WORD);
            err       <= 1'b1;
            state     <= DONE;
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            stall     <= 1'b0;
            op_valid  <= 1'b1;
          end
        end
        RD2: begin
          if (ram.ram_ack) begin
            op2        <= ram.ram_rdata;
            state      <= spw_q ? WR : DONE;
            ram_req_q  <= spw_q;
            ram_we_q   <= spw_q;
            ram_addr_q <= rd_q;
            stall      <= spw_q;
            tmr_load   <= spw_q;
            op_valid   <= !spw_q;
          end else if (tmr_expired) begin
            op2       <= DW'(FILL_WORD);
            err       <= 1'b1;
            state     <= DONE;
            ram_req_q <= 1'b0;
            stall     <= 1'b0;
            op_valid  <= 1'b1;
          end
        end
        WR: begin
          if (ram.ram_ack || tmr_expired) begin
            if (!ram.ram_ack) err <= 1'b1;
            state     <= DONE;
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            stall     <= 1'b0;
            op_valid  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ram_req_q <= 1'b0;
          ram_we_q  <= 1'b0;
          stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ram_sequencer.sv
// Scoreboard bench: stimulus pushes expected RAM transactions and operand
// results; the RAM responder and the op monitor pop and compare them.
module tb_regfile_ram_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        prog_mode = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        use_rs1 = 1'b0, use_rs2 = 1'b0, wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] op1, op2;
  logic        op_valid, stall, err;

  regfile_ram_sequencer_if #(.DW(32), .SPILL_AW(4)) ram_bus ();

  regfile_ram_sequencer #(.DW(32), .SPILL_AW(4), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .prog_mode(prog_mode),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2),
    .wr_en(wr_en), .wr_data(wr_data),
    .op1(op1), .op2(op2), .op_valid(op_valid),
    .stall(stall), .err(err), .ram(ram_bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic we; logic [3:0] addr; logic [31:0] wdata; } ram_tx_t;
  typedef struct { logic [31:0] op1; logic [31:0] op2; logic err; } op_exp_t;

  ram_tx_t     tx_q[$];
  op_exp_t     op_q[$];
  logic [31:0] mem [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  bit          ram_req_seen = 1'b0;
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM responder and transaction monitor
  initial begin
    int      wc;
    ram_tx_t e;
    wc = 0;
    ram_bus.ram_ack = 1'b0;
    ram_bus.ram_rdata = '0;
    forever begin
      @(negedge CLK);
      if (ram_bus.ram_req) ram_req_seen = 1'b1;
      if (ram_bus.ram_ack) begin
        ram_bus.ram_ack = 1'b0;
        wc = 0;
      end else if (ram_bus.ram_req && ack_en && !RESET) begin
        if (wc >= ack_delay) begin
          if (tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ram_tx: unexpected access addr %h we %b", ram_bus.ram_addr, ram_bus.ram_we);
          end else begin
            e = tx_q.pop_front();
            chk("ram_we", ram_bus.ram_we, e.we);
            chk("ram_addr", ram_bus.ram_addr, e.addr);
            if (e.we) chk("ram_wdata", ram_bus.ram_wdata, e.wdata);
          end
          ram_bus.ram_rdata = mem[ram_bus.ram_addr];
          if (ram_bus.ram_we) mem[ram_bus.ram_addr] = ram_bus.ram_wdata;
          ram_bus.ram_ack = 1'b1;
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Operand result monitor
  initial begin
    op_exp_t e;
    forever begin
      @(negedge CLK);
      if (op_valid) begin
        if (op_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL op_result: unexpected op_valid op1 %h op2 %h", op1, op2);
        end else begin
          e = op_q.pop_front();
          chk("op1", op1, e.op1);
          chk("op2", op2, e.op2);
          chk("err", err, e.err);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                       input logic u1, input logic u2, input logic we,
                       input logic [31:0] wd, input bit wait_done, output int latency);
    int k;
    @(negedge CLK);
    rs1 = a1; rs2 = a2; rd = ad;
    use_rs1 = u1; use_rs2 = u2; wr_en = we; wr_data = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("req_ready_before_accept", req_ready, 1'b1);
    @(negedge CLK);
    req_valid = 1'b0;
    latency = 0;
    if (wait_done) begin
      while (!op_valid && latency < 50) begin
        @(negedge CLK);
        latency++;
      end
      chk("op_valid_seen", op_valid, 1'b1);
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[2] = 32'h1111_2222;
    mem[7] = 32'h1234_5678;

    repeat (3) @(negedge CLK);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_ram_req", ram_bus.ram_req, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_stall", stall, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_req_ready", req_ready, 1'b1);

    // no spilled registers: DONE right after accept, RAM untouched
    ram_req_seen = 1'b0;
    op_q.push_back('{32'h0, 32'h0, 1'b0});
    issue(5'h03, 5'h04, 5'h05, 1'b1, 1'b1, 1'b1, 32'h55, 1'b1, lat);
    chk("nospill_latency", lat, 0);
    chk("nospill_no_ram_req", ram_req_seen, 1'b0);

    // rs1 spilled read, rd spilled write
    ack_delay = 2;
    tx_q.push_back('{1'b0, 4'h2, 32'h0});
    tx_q.push_back('{1'b1, 4'hA, 32'hCAFE_0001});
    op_q.push_back('{32'h1111_2222, 32'h0, 1'b0});
    issue(5'h12, 5'h04, 5'h1A, 1'b1, 1'b1, 1'b1, 32'hCAFE_0001, 1'b1, lat);

    // rs1 == rs2 spilled: one read feeds both operands
    ack_delay = 1;
    tx_q.push_back('{1'b0, 4'h7, 32'h0});
    op_q.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0});
    issue(5'h17, 5'h17, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, lat);

    // rd == rs1: read returns the pre-write value; unused rs2 gives 0
    ack_delay = 0;
    tx_q.push_back('{1'b0, 4'hA, 32'h0});
    tx_q.push_back('{1'b1, 4'hA, 32'hDEAD_0000});
    op_q.push_back('{32'hCAFE_0001, 32'h0, 1'b0});
    issue(5'h1A, 5'h1A, 5'h1A, 1'b1, 1'b0, 1'b1, 32'hDEAD_0000, 1'b1, lat);
    chk("mem_A_written", mem[10], 32'hDEAD_0000);

    // two distinct spilled reads; rd = 0 never writes
    ack_delay = 1;
    tx_q.push_back('{1'b0, 4'h2, 32'h0});
    tx_q.push_back('{1'b0, 4'hA, 32'h0});
    op_q.push_back('{32'h1111_2222, 32'hDEAD_0000, 1'b0});
    issue(5'h12, 5'h1A, 5'h00, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, lat);

    // timeout on rs1 read
    ack_en = 1'b0;
    op_q.push_back('{32'hFFFF_FFFF, 32'h0, 1'b1});
    issue(5'h11, 5'h03, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, lat);
    @(negedge CLK);
    chk("timeout_back_idle", req_ready, 1'b1);
    chk("timeout_err_sticky", err, 1'b1);
    chk("timeout_op1_hold", op1, 32'hFFFF_FFFF);
    chk("timeout_op_valid_pulse", op_valid, 1'b0);

    // prog_mode abort while in WR
    issue(5'h03, 5'h00, 5'h15, 1'b1, 1'b0, 1'b1, 32'h77, 1'b0, lat);
    chk("wr_ram_req", ram_bus.ram_req, 1'b1);
    chk("wr_ram_we", ram_bus.ram_we, 1'b1);
    chk("wr_ram_addr", ram_bus.ram_addr, 4'h5);
    prog_mode = 1'b1;
    @(negedge CLK);
    chk("prog_ram_req", ram_bus.ram_req, 1'b0);
    chk("prog_stall", stall, 1'b0);
    chk("prog_err_cleared", err, 1'b0);
    chk("prog_req_ready", req_ready, 1'b0);
    prog_mode = 1'b0;
    @(negedge CLK);
    chk("prog_exit_req_ready", req_ready, 1'b1);

    // asynchronous reset in RD2
    ack_en = 1'b1;
    ack_delay = 2;
    tx_q.push_back('{1'b0, 4'h2, 32'h0});
    issue(5'h12, 5'h13, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, lat);
    k = 0;
    while (!(ram_bus.ram_req && ram_bus.ram_addr == 4'h3) && k < 30) begin
      @(negedge CLK);
      k++;
    end
    chk("reached_rd2", ram_bus.ram_addr, 4'h3);
    RESET = 1'b1;
    #1;
    chk("rst_rd2_ram_req", ram_bus.ram_req, 1'b0);
    chk("rst_rd2_idle", req_ready, 1'b1);
    chk("rst_rd2_stall", stall, 1'b0);
    chk("rst_rd2_op1", op1, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_rd2_release_ready", req_ready, 1'b1);

    repeat (3) @(negedge CLK);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("op_q_empty", op_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
